// File: rtl/monitor_bridge_pkg.sv
// Shared definitions for the monitor bus bridge: register offsets, STATUS bit
// positions and the bus-cycle state encoding.
package monitor_bridge_pkg;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h2;
  localparam logic [3:0] REG_OUTPUT = 4'h4;
  localparam logic [3:0] REG_INPUT  = 4'h6;

  localparam int STAT_SEND_BUSY = 0;
  localparam int STAT_RECEIVED  = 1;
  localparam int STAT_OVR       = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACK     = 3'd3,
    ST_RELEASE = 3'd4
  } bus_state_e;

endpackage

// File: rtl/monitor_strobe_gen.sv
// Fixed-width strobe: a one-cycle start loads the counter, and the output
// stays high for PULSE_CYCLES clocks starting the cycle after start.
module monitor_strobe_gen #(
  parameter int PULSE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic pulse
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= 4'(PULSE_CYCLES);
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign pulse = (cnt != 4'd0);

endmodule

// File: rtl/monitor_bus_bridge.sv
// 68000 bus slave exposing the SPI monitor UART and signal I/O as registers.
// Define MONITOR_BRIDGE_BERR_EN to add the BERR port for unmapped/read-only accesses.
module monitor_bus_bridge
  import monitor_bridge_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR    = 24'hFF0000,
  parameter int          WAIT_CYCLES  = 2,
  parameter int          PULSE_CYCLES = 4
) (
  input  logic        MCLK_IN,
  input  logic        RUN_IN,
  input  logic        AS_IN,
  input  logic        UDS_IN,
  input  logic        LDS_IN,
  input  logic        RW_IN,
  input  logic [23:0] ADDR_IN,
  input  logic [15:0] DATA_IN,
  output logic [15:0] DATA_OUT,
  output logic        DATA_OE,
  output logic        DTACK,
`ifdef MONITOR_BRIDGE_BERR_EN
  output logic        BERR,
`endif
  output logic        UART_SEND_TRIGGER_OUT,
  output logic [7:0]  UART_SEND_BYTE_OUT,
  output logic        UART_RECEIVE_CAPTURE_OUT,
  output logic [3:0]  OUTPUT_SIGNAL_OUT,
  input  logic        UART_SEND_BUSY_IN,
  input  logic        UART_RECEIVED_IN,
  input  logic [7:0]  UART_RECEIVE_BYTE_IN,
  input  logic [3:0]  INPUT_SIGNAL_IN,
  output bus_state_e  state_dbg
);

  bus_state_e  state, next_state;
  logic [1:0]  as_ff, busy_ff, recv_ff;
  logic [3:0]  in_ff1, in_ff2;
  logic        as_sync, busy_sync, recv_sync;
  logic [3:0]  wait_cnt;
  logic [15:0] data_out, rd_mux;
  logic [7:0]  tx_byte, rx_byte;
  logic [3:0]  out_sig;
  logic        ovr, rd_q, err_q, berr_cond;
  logic        send_start, capture_start, send_pulse, capture_pulse;
  logic        in_window, wr_lane, send_blocked;
  logic [3:0]  offset;
  logic        unused;

  assign unused = &{1'b0, UDS_IN, ADDR_IN[0], DATA_IN[15:8]};

  always_ff @(posedge MCLK_IN or negedge RUN_IN) begin
    if (!RUN_IN) begin
      as_ff   <= 2'b11;
      busy_ff <= '0;
      recv_ff <= '0;
      in_ff1  <= '0;
      in_ff2  <= '0;
    end else begin
      as_ff   <= {as_ff[0], AS_IN};
      busy_ff <= {busy_ff[0], UART_SEND_BUSY_IN};
      recv_ff <= {recv_ff[0], UART_RECEIVED_IN};
      in_ff1  <= INPUT_SIGNAL_IN;
      in_ff2  <= in_ff1;
    end
  end

  assign as_sync   = as_ff[1];
  assign busy_sync = busy_ff[1];
  assign recv_sync = recv_ff[1];

  // The 68000 holds address and strobes stable while AS is low, so they are
  // used directly once the synchronized AS has qualified the cycle.
  assign in_window    = (ADDR_IN[23:4] == BASE_ADDR[23:4]);
  assign offset       = {ADDR_IN[3:1], 1'b0};
  assign wr_lane      = !RW_IN && !LDS_IN;
  assign send_blocked = busy_sync || send_pulse;

`ifdef MONITOR_BRIDGE_BERR_EN
  assign berr_cond = offset[3] ||
                     (!RW_IN && (offset == REG_STATUS || offset == REG_INPUT));
`else
  assign berr_cond = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (offset)
      REG_DATA:   rd_mux[7:0] = recv_sync ? UART_RECEIVE_BYTE_IN : rx_byte;
      REG_STATUS: begin
        rd_mux[STAT_SEND_BUSY] = busy_sync;
        rd_mux[STAT_RECEIVED]  = recv_sync;
        rd_mux[STAT_OVR]       = ovr;
      end
      REG_OUTPUT: rd_mux[3:0] = out_sig;
      REG_INPUT:  rd_mux[3:0] = in_ff2;
      default:    rd_mux = '0;
    endcase
  end

  always_comb begin
    next_state    = state;
    send_start    = 1'b0;
    capture_start = 1'b0;
    DTACK         = 1'b1;
    DATA_OE       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!as_sync && in_window) next_state = ST_DECODE;
      end
      ST_DECODE: begin
        next_state    = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
        send_start    = wr_lane && (offset == REG_DATA) && !send_blocked;
        capture_start = RW_IN && (offset == REG_DATA) && recv_sync;
      end
      ST_WAIT: begin
        if (wait_cnt == 4'(WAIT_CYCLES - 1)) next_state = ST_ACK;
      end
      ST_ACK: begin
        DTACK   = err_q;
        DATA_OE = rd_q && !err_q;
        if (as_sync) next_state = ST_RELEASE;
      end
      ST_RELEASE: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

`ifdef MONITOR_BRIDGE_BERR_EN
  assign BERR = !((state == ST_ACK) && err_q);
`endif

  always_ff @(posedge MCLK_IN or negedge RUN_IN) begin
    if (!RUN_IN) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      data_out <= '0;
      rd_q     <= 1'b0;
      err_q    <= 1'b0;
      tx_byte  <= '0;
      rx_byte  <= '0;
      out_sig  <= '0;
      ovr      <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_WAIT) wait_cnt <= wait_cnt + 4'd1;
      if (state == ST_RELEASE) data_out <= '0;
      // All register side effects happen here, once per bus cycle.
      if (state == ST_DECODE) begin
        wait_cnt <= '0;
        rd_q     <= RW_IN;
        err_q    <= berr_cond;
        data_out <= RW_IN ? rd_mux : 16'h0000;
        if (RW_IN) begin
          if (offset == REG_STATUS) ovr <= 1'b0;
          if (offset == REG_DATA && recv_sync) rx_byte <= UART_RECEIVE_BYTE_IN;
        end else if (wr_lane) begin
          if (offset == REG_DATA) begin
            if (send_blocked) ovr <= 1'b1;
            else              tx_byte <= DATA_IN[7:0];
          end
          if (offset == REG_OUTPUT) out_sig <= DATA_IN[3:0];
        end
      end
    end
  end

  monitor_strobe_gen #(.PULSE_CYCLES(PULSE_CYCLES)) u_send_strobe (
    .clk   (MCLK_IN),
    .rst_n (RUN_IN),
    .start (send_start),
    .pulse (send_pulse)
  );

  monitor_strobe_gen #(.PULSE_CYCLES(PULSE_CYCLES)) u_capture_strobe (
    .clk   (MCLK_IN),
    .rst_n (RUN_IN),
    .start (capture_start),
    .pulse (capture_pulse)
  );

  assign DATA_OUT                 = data_out;
  assign UART_SEND_TRIGGER_OUT    = send_pulse;
  assign UART_SEND_BYTE_OUT       = tx_byte;
  assign UART_RECEIVE_CAPTURE_OUT = capture_pulse;
  assign OUTPUT_SIGNAL_OUT        = out_sig;
  assign state_dbg                = state;

endmodule

// File: tb/tb_monitor_bus_bridge.sv
// Bench for monitor_bus_bridge: directed register accesses plus random bus
// cycles scored against a register-level model of the bridge.
module tb_monitor_bus_bridge;
  import monitor_bridge_pkg::*;

  localparam logic [23:0] BASE = 24'hFF0000;
  localparam int W = 2;
  localparam int P = 4;
  localparam int ACK_LAT = 3 + W + 1;
  localparam int REL_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n, as_n, uds_n, lds_n, rw;
  logic [23:0] addr;
  logic [15:0] wdata, rdata;
  logic        data_oe, dtack, berr;
  logic        send_trig, capture;
  logic [7:0]  send_byte, rx_byte;
  logic [3:0]  out_sig, in_sig;
  logic        send_busy, received;
  bus_state_e  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  // register-level model
  logic       m_ovr;
  logic [7:0] m_tx, m_rx_last;
  logic [3:0] m_out;

  int   trig_rises = 0, trig_high = 0, cap_rises = 0, cap_high = 0;
  logic trig_prev = 1'b0, cap_prev = 1'b0;

  monitor_bus_bridge #(.BASE_ADDR(BASE), .WAIT_CYCLES(W), .PULSE_CYCLES(P)) dut (
    .MCLK_IN                  (clk),
    .RUN_IN                   (rst_n),
    .AS_IN                    (as_n),
    .UDS_IN                   (uds_n),
    .LDS_IN                   (lds_n),
    .RW_IN                    (rw),
    .ADDR_IN                  (addr),
    .DATA_IN                  (wdata),
    .DATA_OUT                 (rdata),
    .DATA_OE                  (data_oe),
    .DTACK                    (dtack),
`ifdef MONITOR_BRIDGE_BERR_EN
    .BERR                     (berr),
`endif
    .UART_SEND_TRIGGER_OUT    (send_trig),
    .UART_SEND_BYTE_OUT       (send_byte),
    .UART_RECEIVE_CAPTURE_OUT (capture),
    .OUTPUT_SIGNAL_OUT        (out_sig),
    .UART_SEND_BUSY_IN        (send_busy),
    .UART_RECEIVED_IN         (received),
    .UART_RECEIVE_BYTE_IN     (rx_byte),
    .INPUT_SIGNAL_IN          (in_sig),
    .state_dbg                (state_dbg)
  );

`ifndef MONITOR_BRIDGE_BERR_EN
  assign berr = 1'b1;
`endif

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (send_trig) trig_high++;
    if (send_trig && !trig_prev) trig_rises++;
    if (capture) cap_high++;
    if (capture && !cap_prev) cap_rises++;
    trig_prev = send_trig;
    cap_prev  = capture;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ovr = 1'b0;
    m_tx = 8'h00;
    m_rx_last = 8'h00;
    m_out = 4'h0;
    exp_q.delete();
  endtask

  // driver tasks
  task automatic set_inputs(input logic busy, input logic recv, input logic [7:0] rxb,
                            input logic [3:0] ins);
    @(posedge clk); #1;
    send_busy = busy;
    received  = recv;
    rx_byte   = rxb;
    in_sig    = ins;
    repeat (3) @(posedge clk);
  endtask

  task automatic bus_cycle(input logic [23:0] a, input logic write, input logic [15:0] d,
                           input logic lds, output logic [15:0] rd, output logic oe_seen,
                           output logic dtack_seen, output logic berr_seen,
                           output int lat, output int rel);
    logic got;
    @(posedge clk); #1;
    addr = a; rw = !write; wdata = d; lds_n = lds; uds_n = 1'b0; as_n = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (!dtack || !berr) got = 1'b1;
    end
    rd = rdata; oe_seen = data_oe; dtack_seen = !dtack; berr_seen = !berr;
    @(posedge clk); #1;
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    rel = 0; got = 1'b0;
    while (!got && rel < 20) begin
      @(posedge clk); rel++;
      @(negedge clk);
      if (dtack && berr) got = 1'b1;
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic run_txn(input logic [3:0] off, input logic write, input logic [15:0] d,
                         input logic lds);
    logic [3:0]  o4;
    logic [15:0] rd, exp_rd;
    logic        oe_seen, dtack_seen, berr_seen, exp_berr, exp_trig, exp_cap;
    int          lat, rel, tr0, th0, cr0, ch0;
    o4 = {off[3:1], 1'b0};
    exp_berr = 1'b0; exp_trig = 1'b0; exp_cap = 1'b0; exp_rd = 16'h0000;
`ifdef MONITOR_BRIDGE_BERR_EN
    exp_berr = (o4 >= 4'h8) || (write && (o4 == 4'h2 || o4 == 4'h6));
`endif
    if (!write) begin
      case (o4)
        4'h0: begin
          exp_rd = {8'h00, received ? rx_byte : m_rx_last};
          if (received) begin m_rx_last = rx_byte; exp_cap = 1'b1; end
        end
        4'h2: begin exp_rd = {13'd0, m_ovr, received, send_busy}; m_ovr = 1'b0; end
        4'h4: exp_rd = {12'd0, m_out};
        4'h6: exp_rd = {12'd0, in_sig};
        default: exp_rd = 16'h0000;
      endcase
      exp_q.push_back(exp_rd);
    end else if (!lds) begin
      if (o4 == 4'h0) begin
        if (send_busy) m_ovr = 1'b1;
        else begin m_tx = d[7:0]; exp_trig = 1'b1; end
      end
      if (o4 == 4'h4) m_out = d[3:0];
    end
    tr0 = trig_rises; th0 = trig_high; cr0 = cap_rises; ch0 = cap_high;
    bus_cycle({BASE[23:4], off}, write, d, lds, rd, oe_seen, dtack_seen, berr_seen, lat, rel);
    check("ack_latency", lat, ACK_LAT);
    check("release_latency", rel, REL_LAT);
    check("dtack_low", {31'd0, dtack_seen}, {31'd0, !exp_berr});
`ifdef MONITOR_BRIDGE_BERR_EN
    check("berr_low", {31'd0, berr_seen}, {31'd0, exp_berr});
`endif
    if (!write) begin
      check("read_data", {16'd0, rd}, {16'd0, exp_q.pop_front()});
      check("read_oe", {31'd0, oe_seen}, {31'd0, !exp_berr});
    end else begin
      check("write_oe", {31'd0, oe_seen}, 32'd0);
    end
    check("trig_count", trig_rises - tr0, {31'd0, exp_trig});
    if (exp_trig) check("trig_width", trig_high - th0, P);
    check("cap_count", cap_rises - cr0, {31'd0, exp_cap});
    if (exp_cap) check("cap_width", cap_high - ch0, P);
    check("send_byte", {24'd0, send_byte}, {24'd0, m_tx});
    check("out_sig", {28'd0, out_sig}, {28'd0, m_out});
  endtask

  task automatic foreign_cycle(input logic [23:0] a);
    int acks;
    @(posedge clk); #1;
    addr = a; rw = 1'b1; lds_n = 1'b0; uds_n = 1'b0; as_n = 1'b0;
    acks = 0;
    repeat (15) begin
      @(negedge clk);
      if (!dtack || !berr) acks++;
    end
    check("foreign_no_ack", acks, 0);
    @(posedge clk); #1;
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    logic got;
    int   lat;
    rst_n = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    addr = '0; wdata = '0; send_busy = 1'b0; received = 1'b0; rx_byte = '0; in_sig = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dtack", {31'd0, dtack}, 32'd1);
    check("rst_berr", {31'd0, berr}, 32'd1);
    check("rst_oe", {31'd0, data_oe}, 32'd0);
    check("rst_data", {16'd0, rdata}, 32'd0);
    check("rst_trig", {31'd0, send_trig}, 32'd0);
    check("rst_cap", {31'd0, capture}, 32'd0);
    check("rst_byte", {24'd0, send_byte}, 32'd0);
    check("rst_out", {28'd0, out_sig}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // directed register accesses
    set_inputs(1'b0, 1'b0, 8'h00, 4'h0);
    run_txn(REG_DATA, 1'b1, 16'h0041, 1'b0);
    set_inputs(1'b1, 1'b0, 8'h00, 4'h0);
    run_txn(REG_DATA, 1'b1, 16'h0055, 1'b0);
    run_txn(REG_STATUS, 1'b0, 16'h0000, 1'b0);
    run_txn(REG_STATUS, 1'b0, 16'h0000, 1'b0);
    set_inputs(1'b0, 1'b1, 8'h5A, 4'h0);
    run_txn(REG_DATA, 1'b0, 16'h0000, 1'b0);
    set_inputs(1'b0, 1'b0, 8'h5A, 4'h0);
    run_txn(REG_DATA, 1'b0, 16'h0000, 1'b0);
    run_txn(REG_OUTPUT, 1'b1, 16'h000A, 1'b0);
    run_txn(REG_OUTPUT, 1'b0, 16'h0000, 1'b0);
    set_inputs(1'b0, 1'b0, 8'h00, 4'h3);
    run_txn(REG_INPUT, 1'b0, 16'h0000, 1'b0);
    run_txn(4'hA, 1'b0, 16'h0000, 1'b0);
    run_txn(REG_OUTPUT, 1'b1, 16'h0005, 1'b1);
    run_txn(REG_STATUS, 1'b1, 16'h00FF, 1'b0);
    run_txn(4'h9, 1'b1, 16'h0077, 1'b0);
    foreign_cycle(24'hFE0002);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        set_inputs($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                   8'($urandom), 4'($urandom));
      if ($urandom_range(0, 9) == 0)
        foreign_cycle({4'h1, 20'($urandom)});
      else
        run_txn(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 16'($urandom),
                $urandom_range(0, 5) == 0);
    end

    // reset while the bridge is acknowledging
    set_inputs(1'b0, 1'b1, 8'h99, 4'h0);
    @(posedge clk); #1;
    addr = {BASE[23:4], REG_DATA}; rw = 1'b1; lds_n = 1'b0; uds_n = 1'b0; as_n = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (!dtack) got = 1'b1;
    end
    check("pre_reset_ack", lat, ACK_LAT);
    @(posedge clk); #1;
    rst_n = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    #1;
    check("midrst_dtack", {31'd0, dtack}, 32'd1);
    check("midrst_berr", {31'd0, berr}, 32'd1);
    check("midrst_oe", {31'd0, data_oe}, 32'd0);
    check("midrst_data", {16'd0, rdata}, 32'd0);
    check("midrst_trig", {31'd0, send_trig}, 32'd0);
    check("midrst_cap", {31'd0, capture}, 32'd0);
    check("midrst_byte", {24'd0, send_byte}, 32'd0);
    check("midrst_out", {28'd0, out_sig}, 32'd0);
    check("midrst_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_inputs(1'b0, 1'b0, 8'h00, 4'h0);
    run_txn(REG_STATUS, 1'b0, 16'h0000, 1'b0);
    run_txn(REG_DATA, 1'b1, 16'h00C3, 1'b0);
    run_txn(REG_OUTPUT, 1'b0, 16'h0000, 1'b0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
